split_1x9: RTL and testbench
============================

Name: split_1x9

Overview:
- Inverse of the 9-to-1 merge tree: takes one 8-bit write stream and deals it round-robin across 9 output lanes, lane 0 through lane 8 and then back to lane 0.
- Each lane has its own small first-word-fall-through FIFO, drained by that lane's read enable.
- Sits on the egress side of the 9x1 fabric. It feeds per-lane consumers in the same order that the merge tree consumes lanes 0..8.

Parameters:
- LANES, 9, number of output lanes (pointer width 4 bits fixed; LANES <= 16).
- WIDTH, 8, data width per beat.
- DEPTH, 4, entries per lane FIFO (power of 2, >= 2).

Ports:
- clk_i  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- wen  input  1  write strobe for the input beat.
- i_data  input  WIDTH  input beat.
- ready  output  1  input can accept a beat this cycle.
- ren  input  LANES  per-lane read/pop enable.
- valid  output  LANES  per-lane head entry valid.
- o_data  output  LANES*WIDTH  per-lane head data; lane k occupies bits [k*WIDTH +: WIDTH].
- lane_ptr  output  4  lane that receives the next accepted beat.
- overflow  output  1  sticky flag: write attempted while ready=0.
- underflow  output  1  sticky flag: ren[k] asserted while valid[k]=0.

Behaviour:
- Reset values (cycle after reset sampled high):
  - valid=0, o_data=0, lane_ptr=0, overflow=0, underflow=0.
  - All FIFO pointers and counts cleared.
  - ready=0 while reset is high.
- Reset mid-operation discards all buffered beats. No lane shows valid in the cycle after reset.
- ready = !reset && !full[lane_ptr]. ready is decoded from registered state only; there is no combinational path from ren to ready.
- Accept: wen && ready.
  - Beat is written to the FIFO of lane_ptr.
  - lane_ptr advances by 1, wrapping from LANES-1 to 0.
- Reject: wen && !ready.
  - Beat is dropped, lane_ptr holds, overflow sets.
  - Upstream must hold wen and data until ready is seen high; the drop is an upstream protocol error.
- Latency: a beat accepted at edge N is visible as valid[k]=1 with o_data lane k = beat after edge N, i.e. 1 cycle.
- FIFO head is FWFT: o_data lane k always shows the oldest entry while valid[k]=1.
- Pop: ren[k] && valid[k] removes the head at the edge; the next entry, if any, appears the following cycle.
- ren[k] && !valid[k] is ignored and sets underflow.
- Simultaneous push and pop on the same lane:
  - Both occur and the count is unchanged.
  - If the lane is full, the push is rejected anyway, because ready is already 0.
  - If the lane is empty, the pushed beat becomes valid next cycle; the pop is an underflow.
- Stall semantics: strict round-robin. A full lane_ptr lane blocks all input even if other lanes have space. Lanes are never skipped, which keeps ordering deterministic for the merge side.
- Per-lane count range 0..DEPTH; read/write pointers wrap modulo DEPTH.
- Sticky flags clear only on reset.

Test Plan:
1. Reset, then 9 beats 0x10..0x18 with wen=1 and ren=0 → lane k holds 0x10+k, all valid=9'h1FF, lane_ptr returns to 0, ready=1.
2. Fill: 36 beats 0x00..0x23 with ren=0 → every lane has 4 entries, ready=0 at lane_ptr=0. A 37th wen sets overflow=1 and lane_ptr stays 0. Pulsing ren[0] once makes ready=1 the next cycle.
3. Ordering: after scenario 2, pop lane 3 four times → o_data lane 3 reads 0x03, 0x0C, 0x15, 0x1E, then valid[3]=0.
4. Push and pop together: lane 0 at count 2, wen=1 with lane_ptr=0 and ren[0]=1 in the same cycle → count stays 2, head advances, new beat lands at the tail.
5. Underflow: with lane 5 empty, ren=9'h020 → underflow=1, all FIFO states unchanged, valid[5]=0.
6. Reset mid-stream: after 5 accepted beats, assert reset for 1 cycle → valid=0, lane_ptr=0, flags=0. The next beat 0xAA lands in lane 0.

Source files
------------

// File: rtl/split_1x9.sv
// rtl/split_1x9.sv - round-robin 1-to-LANES stream splitter with per-lane FWFT FIFOs
//
// Purpose: deals each accepted input beat to lane lane_ptr, then advances
// lane_ptr (LANES-1 wraps to 0). Every lane buffers DEPTH beats in a
// first-word-fall-through FIFO that its consumer drains with ren[k].
//
// Ports:
//   clk_i     in   1            clock, all state on rising edge
//   reset     in   1            synchronous active-high reset
//   wen       in   1            input beat write strobe
//   i_data    in   WIDTH        input beat
//   ready     out  1            input beat can be accepted this cycle
//   ren       in   LANES        per-lane pop enable
//   valid     out  LANES        per-lane head entry valid
//   o_data    out  LANES*WIDTH  per-lane head data, lane k at [k*WIDTH +: WIDTH]
//   lane_ptr  out  4            lane receiving the next accepted beat
//   overflow  out  1            sticky: wen seen while ready=0
//   underflow out  1            sticky: ren[k] seen while valid[k]=0
module split_1x9 #(
  parameter int LANES = 9,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset,
  input  logic                   wen,
  input  logic [WIDTH-1:0]       i_data,
  output logic                   ready,
  input  logic [LANES-1:0]       ren,
  output logic [LANES-1:0]       valid,
  output logic [LANES*WIDTH-1:0] o_data,
  output logic [3:0]             lane_ptr,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem    [LANES][DEPTH];
  logic [AW-1:0]    r_rd_ptr [LANES];
  logic [AW-1:0]    r_wr_ptr [LANES];
  logic [CW-1:0]    r_cnt    [LANES];
  logic [3:0]       r_lane_ptr;
  logic             r_overflow;
  logic             r_underflow;

  logic [LANES-1:0] w_valid;
  logic [LANES-1:0] w_full;
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_pop;
  logic             w_ready;
  logic             w_accept;

  always_comb begin
    w_valid = '0;
    w_full  = '0;
    o_data  = '0;
    for (int k = 0; k < LANES; k++) begin
      w_valid[k] = (r_cnt[k] != '0);
      w_full[k]  = (r_cnt[k] == CW'(DEPTH));
      // Head is gated by valid so an empty lane shows zero, not stale memory.
      if (r_cnt[k] != '0) o_data[k*WIDTH +: WIDTH] = r_mem[k][r_rd_ptr[k]];
    end
  end

  // Only registered state feeds ready: a pop this cycle does not free space
  // for a push in the same cycle, even on the lane being written.
  assign w_ready  = !reset && !w_full[r_lane_ptr];
  assign w_accept = wen && w_ready;

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int k = 0; k < LANES; k++) begin
      w_push[k] = w_accept && (r_lane_ptr == 4'(k));
      w_pop[k]  = ren[k] && w_valid[k];
    end
  end

  // Storage is not reset; occupancy is tracked by r_cnt alone.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES; k++) begin
      if (w_push[k]) r_mem[k][r_wr_ptr[k]] <= i_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) begin
        r_rd_ptr[k] <= '0;
        r_wr_ptr[k] <= '0;
        r_cnt[k]    <= '0;
      end
      r_lane_ptr  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (w_push[k]) r_wr_ptr[k] <= r_wr_ptr[k] + AW'(1);
        if (w_pop[k])  r_rd_ptr[k] <= r_rd_ptr[k] + AW'(1);
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + CW'(1);
          2'b01:   r_cnt[k] <= r_cnt[k] - CW'(1);
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
      if (w_accept) begin
        r_lane_ptr <= (r_lane_ptr == 4'(LANES - 1)) ? 4'd0 : r_lane_ptr + 4'd1;
      end
      if (wen && !w_ready)     r_overflow  <= 1'b1;
      if (|(ren & ~w_valid))   r_underflow <= 1'b1;
    end
  end

  assign ready     = w_ready;
  assign valid     = w_valid;
  assign lane_ptr  = r_lane_ptr;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_split_1x9.sv
// tb/tb_split_1x9.sv - randomized self-checking bench for split_1x9 against a queue model
module tb_split_1x9;

  localparam int LANES = 9;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                   clk_i = 1'b0;
  logic                   reset;
  logic                   wen;
  logic [WIDTH-1:0]       i_data;
  logic                   ready;
  logic [LANES-1:0]       ren;
  logic [LANES-1:0]       valid;
  logic [LANES*WIDTH-1:0] o_data;
  logic [3:0]             lane_ptr;
  logic                   overflow;
  logic                   underflow;

  split_1x9 #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i     (clk_i),
    .reset     (reset),
    .wen       (wen),
    .i_data    (i_data),
    .ready     (ready),
    .ren       (ren),
    .valid     (valid),
    .o_data    (o_data),
    .lane_ptr  (lane_ptr),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: one queue per lane, a round-robin index, two sticky flags.
  logic [WIDTH-1:0] m_q [LANES][$];
  int               m_ptr;
  logic             m_ovf;
  logic             m_unf;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < LANES; k++) m_q[k].delete();
    m_ptr = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic compare_all(input logic rst);
    logic [LANES-1:0]       e_valid;
    logic [LANES*WIDTH-1:0] e_data;
    logic                   e_ready;
    e_valid = '0;
    e_data  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (m_q[k].size() > 0) begin
        e_valid[k] = 1'b1;
        e_data[k*WIDTH +: WIDTH] = m_q[k][0];
      end
    end
    e_ready = !rst && (m_q[m_ptr].size() < DEPTH);
    chk("ready",     80'(ready),     80'(e_ready));
    chk("valid",     80'(valid),     80'(e_valid));
    chk("o_data",    80'(o_data),    80'(e_data));
    chk("lane_ptr",  80'(lane_ptr),  80'(m_ptr));
    chk("overflow",  80'(overflow),  80'(m_ovf));
    chk("underflow", 80'(underflow), 80'(m_unf));
  endtask

  task automatic model_edge(input logic w, input logic [WIDTH-1:0] d,
                            input logic [LANES-1:0] r, input logic rst);
    bit rdy;
    if (rst) begin
      model_reset();
    end else begin
      rdy = m_q[m_ptr].size() < DEPTH;
      // Pops look at occupancy before this edge's push.
      for (int k = 0; k < LANES; k++) begin
        if (r[k]) begin
          if (m_q[k].size() > 0) void'(m_q[k].pop_front());
          else m_unf = 1'b1;
        end
      end
      if (w) begin
        if (rdy) begin
          m_q[m_ptr].push_back(d);
          m_ptr = (m_ptr + 1) % LANES;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are compared mid-cycle.
  task automatic step(input logic w, input logic [WIDTH-1:0] d,
                      input logic [LANES-1:0] r, input logic rst);
    wen = w; i_data = d; ren = r; reset = rst;
    #2;
    compare_all(rst);
    @(posedge clk_i);
    model_edge(w, d, r, rst);
    #1;
  endtask

  logic [WIDTH-1:0] lane3_exp [4];

  initial begin
    lane3_exp[0] = 8'h03; lane3_exp[1] = 8'h0C;
    lane3_exp[2] = 8'h15; lane3_exp[3] = 8'h1E;
    wen = 1'b0; i_data = '0; ren = '0; reset = 1'b1;
    @(posedge clk_i);
    model_reset();
    #1;

    // 1: nine beats fill one entry per lane
    step(0, 8'h00, '0, 1);
    for (int i = 0; i < 9; i++) step(1, 8'(8'h10 + i), '0, 0);
    for (int k = 0; k < LANES; k++) chk("s1_lane", 80'(o_data[k*WIDTH +: WIDTH]), 80'(8'h10 + k));
    chk("s1_valid", 80'(valid), 80'(9'h1FF));

    // 2: fill all lanes, overflow, then free lane 0
    step(0, 8'h00, '0, 1);
    for (int i = 0; i < 36; i++) step(1, 8'(i), '0, 0);
    chk("s2_ready_full", 80'(ready), 80'(0));
    step(1, 8'hEE, '0, 0);
    chk("s2_overflow", 80'(overflow), 80'(1));
    chk("s2_ptr_hold", 80'(lane_ptr), 80'(0));
    step(0, 8'h00, 9'h001, 0);
    chk("s2_ready_again", 80'(ready), 80'(1));

    // 3: lane 3 drains in arrival order
    for (int i = 0; i < 4; i++) begin
      chk("s3_lane3", 80'(o_data[3*WIDTH +: WIDTH]), 80'(lane3_exp[i]));
      step(0, 8'h00, 9'h008, 0);
    end
    chk("s3_valid3", 80'(valid[3]), 80'(0));

    // 4: simultaneous push and pop on lane 0 at count 2
    step(0, 8'h00, '0, 1);
    for (int i = 0; i < 18; i++) step(1, 8'(8'h40 + i), '0, 0);
    step(1, 8'h5A, 9'h001, 0);
    chk("s4_head", 80'(o_data[WIDTH-1:0]), 80'(8'h49));
    step(0, 8'h00, 9'h001, 0);
    step(0, 8'h00, '0, 0);
    chk("s4_tail", 80'(o_data[WIDTH-1:0]), 80'(8'h5A));

    // 5: underflow on an empty lane
    step(0, 8'h00, '0, 1);
    step(0, 8'h00, 9'h020, 0);
    chk("s5_underflow", 80'(underflow), 80'(1));
    chk("s5_valid5", 80'(valid[5]), 80'(0));

    // 6: reset mid-stream discards buffered beats
    for (int i = 0; i < 5; i++) step(1, 8'(8'h70 + i), '0, 0);
    step(0, 8'h00, '0, 1);
    chk("s6_valid", 80'(valid), 80'(0));
    chk("s6_ptr", 80'(lane_ptr), 80'(0));
    step(1, 8'hAA, '0, 0);
    chk("s6_lane0", 80'(o_data[WIDTH-1:0]), 80'(8'hAA));

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom),
           9'($urandom & $urandom & $urandom),
           ($urandom_range(0, 299) == 0));
    end
    step(0, 8'h00, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
